// File: rtl/fetch_sequencer.sv
// fetch_sequencer: front-end fetch controller.
// Arbitrates trap/flush/predictor redirects onto the PC generator, issues
// one fetch-block request at a time, kills stale responses after a redirect
// and holds one fetch block toward decode.
// Optional: define FETCH_SEQ_PERF_EN to add perf_req_cnt, perf_redirect_cnt
// and perf_kill_cnt outputs.
module fetch_sequencer #(
  parameter logic [31:0] ResetValue = 32'h8000_0000,
  parameter int unsigned Fetch_Num  = 4
) (
  input  logic                      clock,
  input  logic                      reset_n,
  input  logic [31:0]               pc,
  output logic [31:0]               dnpc,
  output logic                      dnpc_valid,
  output logic                      pc_update,
  input  logic                      trap_valid,
  input  logic [31:0]               trap_pc,
  input  logic                      flush_valid,
  input  logic [31:0]               flush_pc,
  input  logic                      pred_valid,
  input  logic [31:0]               pred_pc,
  output logic                      ifu_req_valid,
  input  logic                      ifu_req_ready,
  output logic [31:0]               ifu_req_addr,
  input  logic                      ifu_resp_valid,
  input  logic [32*Fetch_Num-1:0]   ifu_resp_data,
  output logic                      ifu_resp_ready,
  output logic                      fetch_valid,
  input  logic                      fetch_ready,
  output logic [31:0]               fetch_pc,
  output logic [32*Fetch_Num-1:0]   fetch_data
`ifdef FETCH_SEQ_PERF_EN
  ,
  output logic [31:0]               perf_req_cnt,
  output logic [31:0]               perf_redirect_cnt,
  output logic [31:0]               perf_kill_cnt
`endif
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_REQ,
    S_WAIT,
    S_KILL
  } state_e;

  state_e                    state_q, state_d;
  logic [31:0]               req_pc_q, req_pc_d;
  logic                      fetch_valid_q, fetch_valid_d;
  logic [31:0]               fetch_pc_q, fetch_pc_d;
  logic [32*Fetch_Num-1:0]   fetch_data_q, fetch_data_d;
  logic                      redirect;
  logic                      buf_free;
  logic                      resp_drop;

  // Redirect arbiter: fixed priority trap > flush > predictor, no queuing.
  always_comb begin
    redirect   = trap_valid | flush_valid | pred_valid;
    dnpc       = trap_valid  ? trap_pc  :
                 flush_valid ? flush_pc : pred_pc;
    dnpc_valid = reset_n & redirect;
  end

  // Sequencer next-state, handshakes and one-entry block buffer.
  always_comb begin
    state_d        = state_q;
    req_pc_d       = req_pc_q;
    fetch_valid_d  = fetch_valid_q;
    fetch_pc_d     = fetch_pc_q;
    fetch_data_d   = fetch_data_q;
    ifu_req_valid  = 1'b0;
    ifu_resp_ready = 1'b0;
    pc_update      = 1'b0;
    resp_drop      = 1'b0;
    buf_free       = !fetch_valid_q || fetch_ready;

    if (fetch_valid_q && fetch_ready) begin
      fetch_valid_d = 1'b0;
    end

    case (state_q)
      S_IDLE: begin
        state_d = S_REQ;
      end
      S_REQ: begin
        ifu_req_valid = !redirect && buf_free;
        if (ifu_req_valid && ifu_req_ready) begin
          pc_update = 1'b1;
          req_pc_d  = pc;
          state_d   = S_WAIT;
        end
      end
      S_WAIT: begin
        ifu_resp_ready = 1'b1;
        if (redirect) begin
          if (ifu_resp_valid) begin
            resp_drop = 1'b1;
            state_d   = S_REQ;
          end else begin
            state_d = S_KILL;
          end
        end else if (ifu_resp_valid) begin
          fetch_valid_d = 1'b1;
          fetch_pc_d    = req_pc_q;
          fetch_data_d  = ifu_resp_data;
          state_d       = S_REQ;
        end
      end
      S_KILL: begin
        ifu_resp_ready = 1'b1;
        if (ifu_resp_valid) begin
          resp_drop = 1'b1;
          state_d   = S_REQ;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Any redirect invalidates the buffered block, even one being popped.
    if (redirect) begin
      fetch_valid_d = 1'b0;
    end

    // State only resets at the edge, so handshakes are masked combinationally.
    if (!reset_n) begin
      ifu_req_valid  = 1'b0;
      ifu_resp_ready = 1'b0;
      pc_update      = 1'b0;
      resp_drop      = 1'b0;
    end
  end

  // State and buffer registers.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q       <= S_IDLE;
      req_pc_q      <= ResetValue;
      fetch_valid_q <= 1'b0;
      fetch_pc_q    <= '0;
      fetch_data_q  <= '0;
    end else begin
      state_q       <= state_d;
      req_pc_q      <= req_pc_d;
      fetch_valid_q <= fetch_valid_d;
      fetch_pc_q    <= fetch_pc_d;
      fetch_data_q  <= fetch_data_d;
    end
  end

  assign ifu_req_addr = pc;
  assign fetch_valid  = fetch_valid_q;
  assign fetch_pc     = fetch_pc_q;
  assign fetch_data   = fetch_data_q;

`ifdef FETCH_SEQ_PERF_EN
  logic [31:0] perf_req_q, perf_req_d;
  logic [31:0] perf_redir_q, perf_redir_d;
  logic [31:0] perf_kill_q, perf_kill_d;

  // Performance counter increments; natural 32-bit wrap.
  always_comb begin
    perf_req_d   = perf_req_q   + {31'd0, pc_update};
    perf_redir_d = perf_redir_q + {31'd0, dnpc_valid};
    perf_kill_d  = perf_kill_q  + {31'd0, resp_drop};
  end

  // Performance counter registers.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      perf_req_q   <= '0;
      perf_redir_q <= '0;
      perf_kill_q  <= '0;
    end else begin
      perf_req_q   <= perf_req_d;
      perf_redir_q <= perf_redir_d;
      perf_kill_q  <= perf_kill_d;
    end
  end

  assign perf_req_cnt      = perf_req_q;
  assign perf_redirect_cnt = perf_redir_q;
  assign perf_kill_cnt     = perf_kill_q;
`endif

endmodule

// File: doc/fetch_sequencer.md
# fetch_sequencer

Front-end fetch controller that sequences the PC generator and the instruction-fetch port. It arbitrates redirect sources (trap, backend flush, predictor) onto the generator's `dnpc`/`dnpc_valid`, pulses `pc_update` when a fetch-block request is accepted, and keeps at most one request outstanding. It kills stale responses after a redirect and buffers one fetch block toward decode.

## Interface
- `ResetValue`, 32'h8000_0000, PC after reset; mirrors the PC generator.
- `Fetch_Num`, 4, instructions per fetch block, power of two ≥1; block size is 4*Fetch_Num bytes.
- `clock` input 1: the only clock.
- `reset_n` input 1: reset, synchronous, active-low.
- `pc` input 32: current PC from the PC generator.
- `dnpc` output 32: selected redirect target.
- `dnpc_valid` output 1: redirect this cycle.
- `pc_update` output 1: advance PC to the next block boundary.
- `trap_valid`/`trap_pc` input 1/32: trap or xRET redirect, priority 1 (highest).
- `flush_valid`/`flush_pc` input 1/32: backend mispredict redirect, priority 2.
- `pred_valid`/`pred_pc` input 1/32: predictor redirect, priority 3.
- `ifu_req_valid`/`ifu_req_ready` output/input 1: fetch request handshake.
- `ifu_req_addr` output 32: request address, equal to `pc`.
- `ifu_resp_valid` input 1, `ifu_resp_data` input 32*Fetch_Num: fetch response.
- `ifu_resp_ready` output 1: response accept.
- `fetch_valid`/`fetch_ready` output/input 1: block handshake to decode.
- `fetch_pc` output 32, `fetch_data` output 32*Fetch_Num: buffered block and its request address.

## Operation
- Redirect arbiter (combinational): `dnpc_valid` = any redirect valid. `dnpc` = the highest-priority target. Lower-priority redirects in the same cycle are dropped, not queued.
- FSM states:
  - IDLE: one cycle after reset, then REQ.
  - REQ: `ifu_req_valid`=1 when the buffer is empty or is popped this cycle.
  - WAIT: one request outstanding.
  - KILL: the outstanding response is stale.
- REQ→WAIT on `ifu_req_valid && ifu_req_ready` with no redirect. `pc_update`=1 that cycle. `ifu_req_addr` is latched as `req_pc`.
- REQ with a redirect: `ifu_req_valid` is forced 0 and `pc_update`=0. State stays REQ; the next request uses the new `pc`.
- WAIT: `ifu_resp_ready`=1. On response with no redirect, capture `req_pc`/`ifu_resp_data` into the buffer, set `fetch_valid`, and return to REQ.
- WAIT with a redirect and no response in the same cycle: go to KILL. With a redirect and a response in the same cycle: drop the response and go to REQ.
- KILL: `ifu_resp_ready`=1. The response is discarded; then go to REQ. Further redirects in KILL are applied to PC only.
- Buffer: one entry. Any redirect clears `fetch_valid` at the next edge, including a buffer being popped that cycle.
- `pc_update` and `dnpc_valid` are never both 1.

## Timing
- Reset values:
  - state IDLE
  - `ifu_req_valid`, `pc_update`, `fetch_valid`, `ifu_resp_ready` = 0
  - `fetch_pc`/`fetch_data` = 0
  - `dnpc_valid` forced 0 while `reset_n`=0
- The instruction cache shares `reset_n`; no response survives reset. Reset asserted mid-request returns to IDLE.
- First request: `ifu_req_valid`=1 in the second cycle after `reset_n` rises, with address ResetValue.
- Latency: response at edge N gives `fetch_valid`=1 in cycle N+1. The next request can issue in the same cycle N+1 if `fetch_ready`=1.
- Redirect in cycle N: PC equals the target at N+1. The first request to the target is in N+1 (from REQ) or after the killed response (from WAIT/KILL).
- Unaligned redirect target: the request is issued at the target. The following request is at the next 4*Fetch_Num-aligned address.

## Configuration
- `FETCH_SEQ_PERF_EN` defined: adds output ports `perf_req_cnt`, `perf_redirect_cnt`, `perf_kill_cnt` (32 bits each, wrap at 2^32, reset to 0). They count, respectively:
  - accepted requests
  - `dnpc_valid` cycles
  - discarded responses (dropped in WAIT and discarded in KILL)
- Undefined: these ports and their counters do not exist; all other behaviour is identical.

## Test plan
- Reset release, `ifu_req_ready`=1, response 1 cycle after each request, `fetch_ready`=1:
  - requests at 0x8000_0000, 0x8000_0010, 0x8000_0020
  - `pc_update` pulses once per request
- `trap_valid`=1 (0x8000_0100), `flush_valid`=1 (0x8000_0200) and `pred_valid`=1 in the same cycle: `dnpc`=0x8000_0100, one `dnpc_valid` pulse, `pc_update`=0.
- `flush_valid` (target 0x8000_0044) while in WAIT, response 3 cycles later:
  - the response is discarded; `fetch_valid` stays 0
  - next requests at 0x8000_0044, then 0x8000_0050
- `fetch_ready`=0 with the buffer full: `ifu_req_valid` stays 0. Raise `fetch_ready`: the pop and a new request occur in the same cycle.
- Redirect and response in the same WAIT cycle: the response is dropped and the state returns to REQ. Also with a full buffer: `fetch_valid`=0 next cycle.
- Pull `reset_n` low for one cycle mid-WAIT: all outputs return to reset values, and the first request is again at 0x8000_0000. With `FETCH_SEQ_PERF_EN`, the counters read 0.
